// File: rtl/tx_sched_cmd_arb_pkg.sv
// Shared types for the tx scheduler command arbiter: the sched_cmd_struct layout,
// per-field set/clear opcodes and helpers used when merging commands.
package tx_sched_cmd_arb_pkg;

  localparam int FLOWID_W = 8;
  localparam int TS_W     = 16;

  typedef enum logic [1:0] {
    SC_NOP   = 2'd0,
    SC_SET   = 2'd1,
    SC_CLEAR = 2'd2
  } set_clear_e;

  typedef struct packed {
    set_clear_e      cmd;
    logic [TS_W-1:0] ts;
  } pend_sc_t;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    pend_sc_t            ack_pend;
    pend_sc_t            data_pend;
    pend_sc_t            rt_pend;
  } sched_cmd_struct;

  localparam int SCHED_CMD_W = $bits(sched_cmd_struct);

  // Two field updates can share one command if at most one acts, or both act identically.
  function automatic logic sc_compat(pend_sc_t a, pend_sc_t b);
    return (a.cmd == SC_NOP) || (b.cmd == SC_NOP) || (a == b);
  endfunction

  function automatic pend_sc_t sc_merge(pend_sc_t a, pend_sc_t b);
    return (a.cmd != SC_NOP) ? a : b;
  endfunction

endpackage

// File: rtl/tx_sched_cmd_arb_rr_pick_ptr.sv
// Round-robin pick: first valid source at or after rr_ptr, wrapping at NUM_SRC.
module rr_pick_ptr #(
  parameter int NUM_SRC   = 3,
  parameter int SRC_IDX_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]   val,
  input  logic [SRC_IDX_W-1:0] rr_ptr,
  output logic [SRC_IDX_W-1:0] winner,
  output logic                 any_val
);

  int idx;

  // Scan farthest-first so the closest valid source to rr_ptr is written last.
  always_comb begin
    winner  = '0;
    any_val = |val;
    idx     = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (val[SRC_IDX_W'(idx)]) winner = SRC_IDX_W'(idx);
    end
  end

endmodule

// File: rtl/tx_sched_cmd_arb.sv
// Round-robin arbiter sharing the tx scheduler command port between engines.
// Optional same-flow command merging is enabled by defining TX_SCHED_ARB_MERGE_EN.
module tx_sched_cmd_arb
  import tx_sched_cmd_arb_pkg::*;
#(
  parameter int NUM_SRC = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_SRC-1:0]                    src_arb_cmd_val,
  input  logic [NUM_SRC-1:0][SCHED_CMD_W-1:0]   src_arb_cmd_data,
  output logic [NUM_SRC-1:0]                    arb_src_cmd_rdy,
  output logic                                  arb_tx_sched_cmd_val,
  output logic [SCHED_CMD_W-1:0]                arb_tx_sched_cmd_data,
  input  logic                                  tx_sched_arb_cmd_rdy
);

  localparam int SRC_IDX_W = $clog2(NUM_SRC);

  typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_e;

  arb_state_e             state;
  logic [SRC_IDX_W-1:0]   rr_ptr;
  logic [SRC_IDX_W-1:0]   winner;
  logic                   any_val;
  logic                   load_en;
  logic                   load;
  logic [NUM_SRC-1:0]     grant;
  logic [SCHED_CMD_W-1:0] load_data;

  rr_pick_ptr #(
    .NUM_SRC   (NUM_SRC),
    .SRC_IDX_W (SRC_IDX_W)
  ) u_pick (
    .val     (src_arb_cmd_val),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_val (any_val)
  );

  // A full stage being drained this cycle can take a new command in the same cycle.
  assign load_en = (state == ARB_EMPTY) | tx_sched_arb_cmd_rdy;
  assign load    = load_en & any_val;

`ifdef TX_SCHED_ARB_MERGE_EN
  sched_cmd_struct acc;
  sched_cmd_struct cand;

  // Fold later sources into the winner in index order so each field has at most one actor.
  always_comb begin
    grant         = '0;
    grant[winner] = load;
    acc           = sched_cmd_struct'(src_arb_cmd_data[winner]);
    cand          = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = sched_cmd_struct'(src_arb_cmd_data[i]);
      if (load && src_arb_cmd_val[i] && (i != int'(winner)) &&
          (cand.flowid == acc.flowid) &&
          sc_compat(acc.ack_pend, cand.ack_pend) &&
          sc_compat(acc.data_pend, cand.data_pend) &&
          sc_compat(acc.rt_pend, cand.rt_pend)) begin
        acc.ack_pend  = sc_merge(acc.ack_pend, cand.ack_pend);
        acc.data_pend = sc_merge(acc.data_pend, cand.data_pend);
        acc.rt_pend   = sc_merge(acc.rt_pend, cand.rt_pend);
        grant[i]      = 1'b1;
      end
    end
    load_data = acc;
  end
`else
  always_comb begin
    grant         = '0;
    grant[winner] = load;
    load_data     = src_arb_cmd_data[winner];
  end
`endif

  assign arb_src_cmd_rdy = rst ? '0 : grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= ARB_EMPTY;
      arb_tx_sched_cmd_val  <= 1'b0;
      arb_tx_sched_cmd_data <= '0;
      rr_ptr                <= '0;
    end else if (load) begin
      state                 <= ARB_FULL;
      arb_tx_sched_cmd_val  <= 1'b1;
      arb_tx_sched_cmd_data <= load_data;
      rr_ptr                <= (winner == SRC_IDX_W'(NUM_SRC - 1)) ? '0
                                                                   : winner + SRC_IDX_W'(1);
    end else if ((state == ARB_FULL) && tx_sched_arb_cmd_rdy) begin
      state                 <= ARB_EMPTY;
      arb_tx_sched_cmd_val  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_sched_cmd_arb.sv
// Bench for tx_sched_cmd_arb: per-source command queues, a queue-level model of the
// output stage and grant order, and literal grant-sequence expectations.
module tb_tx_sched_cmd_arb;
  import tx_sched_cmd_arb_pkg::*;

  localparam int N = 3;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic [N-1:0]                    sval;
  logic [N-1:0][SCHED_CMD_W-1:0]   sdata;
  logic [N-1:0]                    rdy_out;
  logic                            oval;
  logic [SCHED_CMD_W-1:0]          odata;
  logic                            sched_rdy;

  sched_cmd_struct sq[N][$];
  bit              mval;
  sched_cmd_struct mdata;
  int              mptr;
  logic [N-1:0]    rlog[$];
  int              nval;
  int              n_cmp;
  int              n_bad;
  sched_cmd_struct oc;

  tx_sched_cmd_arb #(.NUM_SRC(N)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .src_arb_cmd_val       (sval),
    .src_arb_cmd_data      (sdata),
    .arb_src_cmd_rdy       (rdy_out),
    .arb_tx_sched_cmd_val  (oval),
    .arb_tx_sched_cmd_data (odata),
    .tx_sched_arb_cmd_rdy  (sched_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic sched_cmd_struct mk(int fid, int fld, set_clear_e c, int ts);
    sched_cmd_struct r;
    r = '0;
    r.flowid = FLOWID_W'(fid);
    case (fld)
      0:       begin r.ack_pend.cmd  = c; r.ack_pend.ts  = TS_W'(ts); end
      1:       begin r.data_pend.cmd = c; r.data_pend.ts = TS_W'(ts); end
      default: begin r.rt_pend.cmd   = c; r.rt_pend.ts   = TS_W'(ts); end
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] rl(int k);
    return (rlog.size() > k) ? rlog[k] : '1;
  endfunction

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      sval[s]  = (sq[s].size() > 0);
      sdata[s] = (sq[s].size() > 0) ? sq[s][0] : '0;
    end
  endtask

  // Expected grants and load value: oldest queued command of the first waiting source from mptr.
  task automatic model_eval(output logic [N-1:0] g, output sched_cmd_struct d, output int w);
    sched_cmd_struct c;
    g = '0;
    d = mdata;
    w = -1;
    if (mval && !sched_rdy) return;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && sq[(mptr + k) % N].size() > 0) w = (mptr + k) % N;
    end
    if (w < 0) return;
    g[w] = 1'b1;
    d = sq[w][0];
`ifdef TX_SCHED_ARB_MERGE_EN
    for (int s = 0; s < N; s++) begin
      if (s != w && sq[s].size() > 0) begin
        c = sq[s][0];
        if (c.flowid == d.flowid && sc_compat(d.ack_pend, c.ack_pend) &&
            sc_compat(d.data_pend, c.data_pend) && sc_compat(d.rt_pend, c.rt_pend)) begin
          if (d.ack_pend.cmd == SC_NOP)  d.ack_pend  = c.ack_pend;
          if (d.data_pend.cmd == SC_NOP) d.data_pend = c.data_pend;
          if (d.rt_pend.cmd == SC_NOP)   d.rt_pend   = c.rt_pend;
          g[s] = 1'b1;
        end
      end
    end
`endif
  endtask

  task automatic cycle();
    logic [N-1:0]    g;
    sched_cmd_struct d;
    int              w;
    @(negedge clk);
    model_eval(g, d, w);
    chk("src_rdy", rdy_out, g);
    chk("out_val", oval, mval);
    chk("out_data", odata, mdata);
    if (rdy_out != '0) rlog.push_back(rdy_out);
    if (oval) nval++;
    @(posedge clk);
    if (g != '0) begin
      mval  = 1'b1;
      mdata = d;
      mptr  = (w + 1) % N;
      for (int s = 0; s < N; s++) if (g[s]) void'(sq[s].pop_front());
    end else if (mval && sched_rdy) begin
      mval = 1'b0;
    end
    #1 drive();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    mval  = 1'b0;
    mdata = '0;
    mptr  = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    rlog.delete();
    nval = 0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; nval = 0;
    mval = 1'b0; mdata = '0; mptr = 0;
    sched_rdy = 1'b1;
    sq[1].push_back(mk(5, 2, SC_SET, 100));
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_val", oval, 0);
    chk("reset_data", odata, 0);
    chk("reset_rdy_gated", rdy_out, 0);
    rst = 1'b0;

    // single command from src1
    cycle();
    oc = odata;
    chk("t1_out_val", oval, 1);
    chk("t1_out_fid", oc.flowid, 5);
    chk("t1_out_rt", oc.rt_pend.cmd, SC_SET);
    cycle();
    cycle();
    chk("t1_grants", rlog.size(), 1);
    chk("t1_grant0", rl(0), 3'b010);

    // all sources valid continuously
    do_reset();
    for (int s = 0; s < N; s++) begin
      sq[s].push_back(mk(10 + s, 1, SC_SET, s));
      sq[s].push_back(mk(20 + s, 0, SC_CLEAR, s));
    end
    drive();
    repeat (8) cycle();
    chk("t2_grants", rlog.size(), 6);
    chk("t2_outputs", nval, 6);
    for (int k = 0; k < 6; k++) chk("t2_order", rl(k), 3'b001 << (k % 3));

    // scheduler stall while full
    do_reset();
    sq[0].push_back(mk(20, 2, SC_CLEAR, 1));
    sq[0].push_back(mk(21, 2, SC_SET, 2));
    sq[1].push_back(mk(22, 0, SC_SET, 3));
    sched_rdy = 1'b0;
    drive();
    repeat (11) cycle();
    oc = odata;
    chk("t3_stall_grants", rlog.size(), 1);
    chk("t3_stall_fid", oc.flowid, 20);
    chk("t3_stall_val", oval, 1);
    sched_rdy = 1'b1;
    repeat (4) cycle();
    chk("t3_order1", rl(1), 3'b010);
    chk("t3_order2", rl(2), 3'b001);

    // rr wrap from pointer 2
    do_reset();
    sq[1].push_back(mk(30, 0, SC_SET, 4));
    drive();
    repeat (2) cycle();
    sq[0].push_back(mk(31, 1, SC_SET, 5));
    sq[2].push_back(mk(32, 1, SC_CLEAR, 6));
    drive();
    repeat (3) cycle();
    for (int s = 0; s < N; s++) sq[s].push_back(mk(33 + s, 2, SC_SET, 7));
    drive();
    repeat (5) cycle();
    chk("t4_wrap_first", rl(1), 3'b100);
    chk("t4_wrap_second", rl(2), 3'b001);
    chk("t4_ptr_after", rl(3), 3'b010);

    // async reset while full
    do_reset();
    sched_rdy = 1'b0;
    sq[0].push_back(mk(40, 0, SC_SET, 8));
    sq[0].push_back(mk(41, 0, SC_SET, 9));
    sq[1].push_back(mk(42, 1, SC_SET, 10));
    sq[2].push_back(mk(43, 2, SC_SET, 11));
    drive();
    cycle();
    #3 rst = 1'b1;
    mval = 1'b0; mdata = '0; mptr = 0;
    #1;
    chk("t5_rst_val", oval, 0);
    chk("t5_rst_data", odata, 0);
    chk("t5_rst_rdy", rdy_out, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sched_rdy = 1'b1;
    rlog.delete();
    repeat (5) cycle();
    chk("t5_first_after_rst", rl(0), 3'b001);

`ifdef TX_SCHED_ARB_MERGE_EN
    do_reset();
    sq[0].push_back(mk(7, 2, SC_SET, 10));
    sq[1].push_back(mk(7, 0, SC_SET, 20));
    drive();
    cycle();
    oc = odata;
    chk("m_rdy", rl(0), 3'b011);
    chk("m_ack", oc.ack_pend.cmd, SC_SET);
    chk("m_ack_ts", oc.ack_pend.ts, 20);
    chk("m_rt", oc.rt_pend.cmd, SC_SET);
    sq[0].push_back(mk(7, 2, SC_SET, 11));
    sq[1].push_back(mk(7, 2, SC_CLEAR, 12));
    drive();
    repeat (4) cycle();
    chk("m_nomerge1", rl(1), 3'b010);
    chk("m_nomerge2", rl(2), 3'b001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
